// File: rtl/seven_segment_scanner_pkg.sv
// Shared types and helpers for the seven-segment digit scanner.
package seven_segment_scanner_pkg;

   // Scanner phase: a digit is either lit (StShow) or all anodes are dark (StBlank).
   typedef enum logic {
      StBlank = 1'b0,
      StShow  = 1'b1
   } scan_state_e;

   // Ceiling log2; returns 0 for n <= 1.
   function automatic int unsigned clog2(input int unsigned n);
      int unsigned w;
      w = 0;
      while ((64'd1 << w) < 64'(n)) begin
         w++;
      end
      return w;
   endfunction

   // Bits needed to count 0..n-1, never less than one.
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n <= 2) ? 1 : clog2(n);
   endfunction

   // Anode level that lights a digit for the given polarity.
   function automatic logic anode_on(input bit act_low);
      return ~act_low;
   endfunction

   // Anode level that keeps a digit dark for the given polarity.
   function automatic logic anode_off(input bit act_low);
      return act_low;
   endfunction

endpackage

// File: rtl/seven_segment_scanner_if.sv
// Digit data in, multiplexed display drive out.
interface seven_segment_scanner_if #(
   parameter int unsigned NUM_DIGITS = 4
) ();
   import seven_segment_scanner_pkg::*;

   localparam int unsigned IdxW = clog2(NUM_DIGITS);

   logic [4*NUM_DIGITS-1:0] digits_in;
   logic [NUM_DIGITS-1:0]   dp_in;
   logic [NUM_DIGITS-1:0]   blank_mask;
   logic                    load;
   logic [3:0]              hex;
   logic [NUM_DIGITS-1:0]   anode;
   logic                    dp;
   logic [IdxW-1:0]         digit_idx;
   logic                    frame_done;

   // Producer of digit values, consumer of the display drive.
   modport master (
      output digits_in, dp_in, blank_mask, load,
      input  hex, anode, dp, digit_idx, frame_done
   );

   // The scanner itself.
   modport slave (
      input  digits_in, dp_in, blank_mask, load,
      output hex, anode, dp, digit_idx, frame_done
   );

endinterface

// File: rtl/seven_segment_scanner_tick_gen.sv
// Up counter that pulses on reaching a programmable terminal value and then reloads to zero.
module scan_tick_gen #(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [CNT_W-1:0] limit,
   output logic             tick
);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   assign tick = (cnt_q == limit);

   // Reload on the terminal count so the next phase starts from zero.
   always_comb begin
      cnt_d = cnt_q + 1'b1;
      if (tick) begin
         cnt_d = '0;
      end
   end

   // Count register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/seven_segment_scanner.sv
// Time-multiplexed digit scanner: lights one digit at a time with a dark gap between digits,
// and swaps in newly loaded values only at frame boundaries.
module seven_segment_scanner
   import seven_segment_scanner_pkg::*;
#(
   parameter int unsigned NUM_DIGITS    = 4,
   parameter int unsigned REFRESH_DIV   = 50000,
   parameter int unsigned BLANK_CYCLES  = 500,
   parameter bit          ANODE_ACT_LOW = 1'b1
) (
   input logic                    clk,
   input logic                    rst_n,
   seven_segment_scanner_if.slave bus
);

   localparam int unsigned IdxW   = clog2(NUM_DIGITS);
   localparam int unsigned MaxCnt = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
   localparam int unsigned CntW   = cnt_width(MaxCnt);

   localparam logic [CntW-1:0] ShowLim  = CntW'(REFRESH_DIV - 1);
   // A zero-length gap still needs one cycle to leave the post-reset BLANK.
   localparam logic [CntW-1:0] BlankLim = CntW'((BLANK_CYCLES == 0) ? 0 : BLANK_CYCLES - 1);
   localparam logic [IdxW-1:0] IdxLast  = IdxW'(NUM_DIGITS - 1);

   logic            tick;
   logic [CntW-1:0] limit;

   scan_state_e     state_q, state_d;
   logic [IdxW-1:0] idx_q, idx_d;
   logic            first_q, first_d;
   logic            advance, start, wrap, swap;

   logic [4*NUM_DIGITS-1:0] act_dig_q, act_dig_d, pend_dig_q, pend_dig_d;
   logic [NUM_DIGITS-1:0]   act_dp_q, act_dp_d, pend_dp_q, pend_dp_d;
   logic                    pend_v_q, pend_v_d;

   logic [3:0]            hex_q, hex_d;
   logic [NUM_DIGITS-1:0] anode_q, anode_d;
   logic                  dp_q, dp_d;
   logic                  fd_q, fd_d;
   logic                  lit;

   assign limit = (state_q == StShow) ? ShowLim : BlankLim;

   scan_tick_gen #(
      .CNT_W(CntW)
   ) u_tick (
      .clk  (clk),
      .rst_n(rst_n),
      .limit(limit),
      .tick (tick)
   );

   // Phase sequencing and digit index advance.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      first_d = first_q;
      advance = 1'b0;
      start   = 1'b0;
      wrap    = 1'b0;
      if (tick) begin
         unique case (state_q)
            StShow: begin
               if (BLANK_CYCLES == 0) begin
                  advance = 1'b1;
               end else begin
                  state_d = StBlank;
               end
            end
            StBlank: begin
               state_d = StShow;
               // The first SHOW after reset stays on digit 0.
               if (first_q) begin
                  first_d = 1'b0;
                  start   = 1'b1;
               end else begin
                  advance = 1'b1;
               end
            end
            default: state_d = StBlank;
         endcase
      end
      if (advance) begin
         if (idx_q == IdxLast) begin
            idx_d = '0;
            wrap  = 1'b1;
         end else begin
            idx_d = idx_q + 1'b1;
         end
      end
      swap = wrap | start;
   end

   // Pending capture and frame-boundary swap into the active set.
   always_comb begin
      act_dig_d  = act_dig_q;
      act_dp_d   = act_dp_q;
      pend_dig_d = pend_dig_q;
      pend_dp_d  = pend_dp_q;
      pend_v_d   = pend_v_q;
      if (bus.load) begin
         pend_dig_d = bus.digits_in;
         pend_dp_d  = bus.dp_in;
         pend_v_d   = 1'b1;
      end
      if (swap) begin
         // A load on the swap cycle bypasses pending and is shown in this frame.
         if (bus.load) begin
            act_dig_d = bus.digits_in;
            act_dp_d  = bus.dp_in;
         end else if (pend_v_q) begin
            act_dig_d = pend_dig_q;
            act_dp_d  = pend_dp_q;
         end
         pend_v_d = 1'b0;
      end
   end

   // Output drive computed from next state so it lines up with the state/index change.
   always_comb begin
      hex_d   = hex_q;
      anode_d = {NUM_DIGITS{anode_off(ANODE_ACT_LOW)}};
      dp_d    = 1'b0;
      fd_d    = wrap;
      lit     = (state_d == StShow) && !bus.blank_mask[idx_d];
      if (state_d == StShow) begin
         hex_d = act_dig_d[4*idx_d +: 4];
      end
      if (lit) begin
         anode_d[idx_d] = anode_on(ANODE_ACT_LOW);
         dp_d           = act_dp_d[idx_d];
      end
   end

   // State, data and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StBlank;
         idx_q      <= '0;
         first_q    <= 1'b1;
         act_dig_q  <= '0;
         act_dp_q   <= '0;
         pend_dig_q <= '0;
         pend_dp_q  <= '0;
         pend_v_q   <= 1'b0;
         hex_q      <= '0;
         anode_q    <= {NUM_DIGITS{anode_off(ANODE_ACT_LOW)}};
         dp_q       <= 1'b0;
         fd_q       <= 1'b0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         first_q    <= first_d;
         act_dig_q  <= act_dig_d;
         act_dp_q   <= act_dp_d;
         pend_dig_q <= pend_dig_d;
         pend_dp_q  <= pend_dp_d;
         pend_v_q   <= pend_v_d;
         hex_q      <= hex_d;
         anode_q    <= anode_d;
         dp_q       <= dp_d;
         fd_q       <= fd_d;
      end
   end

   assign bus.hex        = hex_q;
   assign bus.anode      = anode_q;
   assign bus.dp         = dp_q;
   assign bus.digit_idx  = idx_q;
   assign bus.frame_done = fd_q;

endmodule

// File: tb/tb_seven_segment_scanner.sv
// Bench for seven_segment_scanner: hand table for the first frame, directed corner sequences,
// random traffic against a slot-arithmetic reference model, and a zero-gap build monitor.
module tb_seven_segment_scanner;

   localparam int ND = 4;
   localparam int RD = 4;
   localparam int BC = 1;
   localparam int P  = RD + BC;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic        ld;
   logic [15:0] din;
   logic [3:0]  dpi;
   logic [3:0]  msk;

   seven_segment_scanner_if #(.NUM_DIGITS(ND)) bus ();
   seven_segment_scanner_if #(.NUM_DIGITS(ND)) bus0 ();

   assign bus.load        = ld;
   assign bus.digits_in   = din;
   assign bus.dp_in       = dpi;
   assign bus.blank_mask  = msk;
   assign bus0.load       = ld;
   assign bus0.digits_in  = din;
   assign bus0.dp_in      = dpi;
   assign bus0.blank_mask = '0;

   seven_segment_scanner #(
      .NUM_DIGITS(ND), .REFRESH_DIV(RD), .BLANK_CYCLES(BC), .ANODE_ACT_LOW(1'b1)
   ) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus.slave)
   );

   seven_segment_scanner #(
      .NUM_DIGITS(ND), .REFRESH_DIV(RD), .BLANK_CYCLES(0), .ANODE_ACT_LOW(1'b1)
   ) dut0 (
      .clk(clk), .rst_n(rst_n), .bus(bus0.slave)
   );

   int errors = 0;
   int checks = 0;

   // Reference model: edge k (1-based after reset release) lies in slot (k-1)/P at offset
   // (k-1)%P; the digit is lit for the first RD offsets of each slot.
   int         k;
   logic [3:0] m_act[ND];
   logic [3:0] m_pend[ND];
   logic       m_adp[ND];
   logic       m_pdp[ND];
   logic       m_pv;
   logic [3:0] e_hex;
   logic [3:0] e_an;
   logic       e_dp;
   int         e_idx;
   logic       e_fd;

   task automatic check(input string name, input int unsigned act, input int unsigned exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (edge %0d)", name, act, exp, k);
      end
   endtask

   task automatic model_reset();
      k = 0;
      for (int i = 0; i < ND; i++) begin
         m_act[i] = '0; m_pend[i] = '0; m_adp[i] = 1'b0; m_pdp[i] = 1'b0;
      end
      m_pv  = 1'b0;
      e_hex = '0; e_an = 4'hF; e_dp = 1'b0; e_idx = 0; e_fd = 1'b0;
   endtask

   task automatic model_edge();
      int   r, s, idx;
      logic show, swp, on;
      k++;
      r    = (k - 1) % P;
      s    = (k - 1) / P;
      idx  = s % ND;
      show = (r < RD);
      swp  = (r == 0) && (idx == 0);
      if (swp) begin
         for (int i = 0; i < ND; i++) begin
            if (ld) begin
               m_act[i] = din[4*i +: 4]; m_adp[i] = dpi[i];
            end else if (m_pv) begin
               m_act[i] = m_pend[i]; m_adp[i] = m_pdp[i];
            end
         end
         m_pv = 1'b0;
      end
      if (ld) begin
         for (int i = 0; i < ND; i++) begin
            m_pend[i] = din[4*i +: 4]; m_pdp[i] = dpi[i];
         end
         if (!swp) m_pv = 1'b1;
      end
      e_idx = idx;
      e_fd  = swp && (s > 0);
      if (show) e_hex = m_act[idx];
      on   = show && !msk[idx];
      e_an = 4'hF;
      if (on) e_an[idx] = 1'b0;
      e_dp = on && m_adp[idx];
   endtask

   task automatic cmp_model();
      check("hex", bus.hex, e_hex);
      check("anode", bus.anode, e_an);
      check("dp", bus.dp, e_dp);
      check("digit_idx", bus.digit_idx, e_idx);
      check("frame_done", bus.frame_done, e_fd);
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      cmp_model();
   endtask

   task automatic run_to(input int e);
      while (k < e) step();
   endtask

   task automatic load_step(input logic [15:0] d, input logic [3:0] p);
      ld = 1'b1; din = d; dpi = p;
      step();
      ld = 1'b0; din = 16'($urandom); dpi = 4'($urandom);
   endtask

   typedef struct {
      logic        ld;
      logic [15:0] din;
      logic [3:0]  dpi;
      logic [3:0]  hex;
      logic [3:0]  an;
      logic        dp;
      int          idx;
      logic        fd;
   } vec_t;

   vec_t tbl[21];

   // Zero-gap build: no dark cycle between digits, frame_done every 16 cycles.
   int e2, last2, viol2 = 0, bad2 = 0, nfd2 = 0;
   initial begin
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            e2 = -1; last2 = 0;
         end else begin
            e2++;
            if (e2 >= 1 && bus0.anode == 4'hF) viol2++;
            if (bus0.frame_done) begin
               nfd2++;
               if (last2 == 0) begin
                  if (e2 != 17) bad2++;
               end else if (e2 - last2 != 16) begin
                  bad2++;
               end
               last2 = e2;
            end
         end
      end
   end

   initial begin
      // First frame after reset: load 4321 with dp on digit 0, taken at the first SHOW.
      tbl[0]  = '{1'b1, 16'h4321, 4'b0001, 4'h1, 4'b1110, 1'b1, 0, 1'b0};
      tbl[1]  = '{1'b0, 16'h9999, 4'b1111, 4'h1, 4'b1110, 1'b1, 0, 1'b0};
      tbl[2]  = '{1'b0, 16'h0000, 4'b0000, 4'h1, 4'b1110, 1'b1, 0, 1'b0};
      tbl[3]  = '{1'b0, 16'h0000, 4'b0000, 4'h1, 4'b1110, 1'b1, 0, 1'b0};
      tbl[4]  = '{1'b0, 16'h0000, 4'b0000, 4'h1, 4'b1111, 1'b0, 0, 1'b0};
      tbl[5]  = '{1'b0, 16'h0000, 4'b0000, 4'h2, 4'b1101, 1'b0, 1, 1'b0};
      tbl[6]  = '{1'b0, 16'h0000, 4'b0000, 4'h2, 4'b1101, 1'b0, 1, 1'b0};
      tbl[7]  = '{1'b0, 16'h0000, 4'b0000, 4'h2, 4'b1101, 1'b0, 1, 1'b0};
      tbl[8]  = '{1'b0, 16'h0000, 4'b0000, 4'h2, 4'b1101, 1'b0, 1, 1'b0};
      tbl[9]  = '{1'b0, 16'h0000, 4'b0000, 4'h2, 4'b1111, 1'b0, 1, 1'b0};
      tbl[10] = '{1'b0, 16'h0000, 4'b0000, 4'h3, 4'b1011, 1'b0, 2, 1'b0};
      tbl[11] = '{1'b0, 16'h0000, 4'b0000, 4'h3, 4'b1011, 1'b0, 2, 1'b0};
      tbl[12] = '{1'b0, 16'h0000, 4'b0000, 4'h3, 4'b1011, 1'b0, 2, 1'b0};
      tbl[13] = '{1'b0, 16'h0000, 4'b0000, 4'h3, 4'b1011, 1'b0, 2, 1'b0};
      tbl[14] = '{1'b0, 16'h0000, 4'b0000, 4'h3, 4'b1111, 1'b0, 2, 1'b0};
      tbl[15] = '{1'b0, 16'h0000, 4'b0000, 4'h4, 4'b0111, 1'b0, 3, 1'b0};
      tbl[16] = '{1'b0, 16'h0000, 4'b0000, 4'h4, 4'b0111, 1'b0, 3, 1'b0};
      tbl[17] = '{1'b0, 16'h0000, 4'b0000, 4'h4, 4'b0111, 1'b0, 3, 1'b0};
      tbl[18] = '{1'b0, 16'h0000, 4'b0000, 4'h4, 4'b0111, 1'b0, 3, 1'b0};
      tbl[19] = '{1'b0, 16'h0000, 4'b0000, 4'h4, 4'b1111, 1'b0, 3, 1'b0};
      tbl[20] = '{1'b0, 16'h0000, 4'b0000, 4'h1, 4'b1110, 1'b1, 0, 1'b1};

      ld = 1'b0; din = '0; dpi = '0; msk = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check("rst_hex", bus.hex, 0);
      check("rst_anode", bus.anode, 4'hF);
      check("rst_dp", bus.dp, 0);
      check("rst_idx", bus.digit_idx, 0);
      check("rst_frame_done", bus.frame_done, 0);
      @(posedge clk);
      #1 rst_n = 1'b1;

      for (int i = 0; i < 21; i++) begin
         ld = tbl[i].ld; din = tbl[i].din; dpi = tbl[i].dpi;
         @(posedge clk);
         model_edge();
         #1;
         check("tbl_hex", bus.hex, tbl[i].hex);
         check("tbl_anode", bus.anode, tbl[i].an);
         check("tbl_dp", bus.dp, tbl[i].dp);
         check("tbl_idx", bus.digit_idx, tbl[i].idx);
         check("tbl_frame_done", bus.frame_done, tbl[i].fd);
      end
      ld = 1'b0;

      // Mid-frame load is held until the next frame.
      run_to(31);
      load_step(16'hABCD, 4'b0001);
      check("t2_old_d2", bus.hex, 4'h3);
      run_to(36);
      check("t2_old_d3", bus.hex, 4'h4);
      run_to(41);
      check("t2_new_d0", bus.hex, 4'hD);
      check("t2_wrap_fd", bus.frame_done, 1);

      // Two loads in one frame: only the last one is shown.
      run_to(42);
      load_step(16'h1111, 4'b0001);
      run_to(49);
      load_step(16'h2222, 4'b0001);
      run_to(60);
      for (int e = 61; e <= 80; e++) begin
         step();
         if ((k - 1) % P < RD) check("t3_only_2s", bus.hex, 4'h2);
      end

      // Load on the wrap cycle goes straight into the current frame.
      load_step(16'h5555, 4'b0001);
      check("t4_same_frame", bus.hex, 4'h5);

      // Masked digit stays dark; dp only with digit 0 lit.
      msk = 4'b0100;
      run_to(91);
      check("t5_masked_anode", bus.anode, 4'hF);
      check("t5_masked_dp", bus.dp, 0);
      run_to(101);
      check("t5_dp_anode", bus.anode, 4'b1110);
      check("t5_dp", bus.dp, 1);
      msk = '0;

      for (int n = 0; n < 300; n++) begin
         ld  = ($urandom_range(0, 7) == 0);
         din = 16'($urandom);
         dpi = 4'($urandom);
         msk = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
         step();
      end
      ld = 1'b0; msk = '0;

      // Asynchronous reset while digit 1 is lit.
      for (int n = 0; n < 40 && !(e_idx == 1 && (k - 1) % P == 1); n++) step();
      check("t6_reached_idx1", ((e_idx == 1) && ((k - 1) % P == 1)) ? 1 : 0, 1);
      #2 rst_n = 1'b0;
      #1;
      check("t6_rst_anode", bus.anode, 4'hF);
      check("t6_rst_dp", bus.dp, 0);
      check("t6_rst_hex", bus.hex, 0);
      check("t6_rst_fd", bus.frame_done, 0);
      check("t6_rst_idx", bus.digit_idx, 0);
      model_reset();
      @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (45) step();

      check("t7_no_dark_gap", viol2, 0);
      check("t7_frame_period", bad2, 0);
      check("t7_frames_seen", (nfd2 > 0) ? 1 : 0, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
